// File: rtl/edf_queue_scheduler.sv
// Earliest-deadline-first arbiter that drains per-requester queues onto one downstream port.
// Each queue owns a deadline counter; the nearest eligible deadline wins in IDLE.
//
// state  | meaning
// IDLE   | pick the eligible queue with the smallest deadline
// SEND   | present the winner's head entry, wait for the handshake
// SETTLE | one bubble so the queue's head and empty flag catch up
module edf_queue_scheduler #(
    parameter int NB_QUEUES     = 4,
    parameter int DATA_SIZE     = 8,
    parameter int REGISTER_SIZE = 32
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [NB_QUEUES*REGISTER_SIZE-1:0]   periods,
    input  logic [NB_QUEUES-1:0]                 q_empty,
    input  logic [NB_QUEUES*DATA_SIZE-1:0]       q_data,
    output logic [NB_QUEUES-1:0]                 q_consumed,
    output logic [DATA_SIZE-1:0]                 m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [$clog2(NB_QUEUES)-1:0]         m_source,
    output logic                                 busy,
    output logic [NB_QUEUES-1:0]                 miss
);
    localparam int SRC_W = $clog2(NB_QUEUES);

    typedef enum logic [1:0] {IDLE, SEND, SETTLE} state_t;

    state_t                   state, state_nxt;
    logic [SRC_W-1:0]         sel, winner;
    logic                     any_eligible;
    logic [REGISTER_SIZE-1:0] best;
    logic [REGISTER_SIZE-1:0] deadline [NB_QUEUES];
    logic [REGISTER_SIZE-1:0] period_q [NB_QUEUES];
    logic [DATA_SIZE-1:0]     head     [NB_QUEUES];
    logic [NB_QUEUES-1:0]     eligible;
    logic [NB_QUEUES-1:0]     miss_set;

    always_comb begin
        for (int i = 0; i < NB_QUEUES; i++) begin
            period_q[i] = periods[i*REGISTER_SIZE +: REGISTER_SIZE];
            head[i]     = q_data[i*DATA_SIZE +: DATA_SIZE];
            eligible[i] = !q_empty[i] && (period_q[i] != '0);
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        any_eligible = 1'b0;
        winner       = '0;
        best         = '0;
        for (int i = 0; i < NB_QUEUES; i++) begin
            if (eligible[i] && (!any_eligible || deadline[i] < best)) begin
                any_eligible = 1'b1;
                winner       = SRC_W'(i);
                best         = deadline[i];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        q_consumed = '0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_source   = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable && any_eligible) state_nxt = SEND;
            end
            SEND: begin
                m_valid  = 1'b1;
                m_data   = head[sel];
                m_source = sel;
                if (m_ready) begin
                    q_consumed[sel] = 1'b1;
                    state_nxt       = SETTLE;
                end
            end
            SETTLE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == SEND) sel <= winner;
        end
    end

    // Reload (pop or disabled) takes priority over aging.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NB_QUEUES; i++) deadline[i] <= '0;
        end else begin
            for (int i = 0; i < NB_QUEUES; i++) begin
                if (q_consumed[i] || !enable)
                    deadline[i] <= period_q[i];
                else if (deadline[i] != '0)
                    deadline[i] <= deadline[i] - REGISTER_SIZE'(1);
            end
        end
    end

    always_comb begin
        miss_set = '0;
        for (int i = 0; i < NB_QUEUES; i++) begin
            miss_set[i] = enable && (deadline[i] == '0) && !q_empty[i]
                          && !(state == SEND && sel == SRC_W'(i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) miss <= '0;
        else       miss <= miss | miss_set;
    end

endmodule

// File: tb/tb_edf_queue_scheduler.sv
// Bench for edf_queue_scheduler: queue models feed the DUT, a scoreboard checks every transfer,
// a vector table checks first-grant selection, and directed sequences cover the multi-cycle cases.
module tb_edf_queue_scheduler;
    localparam int NQ = 4;
    localparam int DW = 8;
    localparam int RW = 32;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic               m_ready = 1'b0;
    logic [NQ*RW-1:0]   periods = '0;
    logic [NQ-1:0]      q_empty;
    logic [NQ*DW-1:0]   q_data;
    logic [NQ-1:0]      q_consumed;
    logic [DW-1:0]      m_data;
    logic               m_valid;
    logic [1:0]         m_source;
    logic               busy;
    logic [NQ-1:0]      miss;

    edf_queue_scheduler #(.NB_QUEUES(NQ), .DATA_SIZE(DW), .REGISTER_SIZE(RW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .periods(periods),
        .q_empty(q_empty), .q_data(q_data), .q_consumed(q_consumed),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_source(m_source), .busy(busy), .miss(miss)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] src;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   hs_cyc[$];

    typedef struct {
        logic [NQ-1:0][RW-1:0] p;
        logic [NQ-1:0]         mask;
        logic                  grant;
        logic [1:0]            src;
    } vec_t;
    vec_t vecs[8];

    // Queue models: written by the stimulus (tail) and popped on q_consumed (head).
    logic [7:0] qmem [NQ][16];
    int         wr_ptr [NQ];
    int         rd_ptr [NQ];

    always_comb begin
        q_empty = '0;
        q_data  = '0;
        for (int i = 0; i < NQ; i++) begin
            q_empty[i]         = (wr_ptr[i] == rd_ptr[i]);
            q_data[i*DW +: DW] = qmem[i][rd_ptr[i] % 16];
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NQ; i++) rd_ptr[i] <= 0;
        end else begin
            for (int i = 0; i < NQ; i++)
                if (q_consumed[i] && rd_ptr[i] != wr_ptr[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: got source %0d data 0x%0h, required no transfer",
                             m_source, m_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("xfer_data", m_data, mon_e.data);
                    check("xfer_source", m_source, mon_e.src);
                    check("xfer_consumed", q_consumed, 4'b0001 << mon_e.src);
                    hs_cyc.push_back(cyc);
                end
            end else begin
                check("no_xfer_consumed", q_consumed, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int q, input logic [7:0] d);
        qmem[q][wr_ptr[q] % 16] = d;
        wr_ptr[q]++;
    endtask

    task automatic expect_xfer(input logic [7:0] d, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        periods = '0;
        for (int i = 0; i < NQ; i++) wr_ptr[i] = 0;
        sb.delete();
        hs_cyc.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check({name, "_drain"}, sb.size(), 0);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // periods are {q3,q2,q1,q0}
        vecs[0] = '{{32'd3, 32'd7, 32'd9, 32'd5}, 4'b1111, 1'b1, 2'd3};
        vecs[1] = '{{32'd3, 32'd7, 32'd9, 32'd5}, 4'b0111, 1'b1, 2'd0};
        vecs[2] = '{{32'd8, 32'd8, 32'd8, 32'd8}, 4'b1111, 1'b1, 2'd0};
        vecs[3] = '{{32'd0, 32'd2, 32'd2, 32'd0}, 4'b1111, 1'b1, 2'd1};
        vecs[4] = '{{32'd9, 32'd4, 32'd4, 32'd6}, 4'b1101, 1'b1, 2'd2};
        vecs[5] = '{{32'd1, 32'd0, 32'd1, 32'd1}, 4'b1000, 1'b1, 2'd3};
        vecs[6] = '{{32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF}, 4'b0011, 1'b1, 2'd1};
        vecs[7] = '{{32'd0, 32'd0, 32'd0, 32'd0}, 4'b1111, 1'b0, 2'd0};

        do_reset();
        @(negedge clock);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_source", m_source, 0);
        check("rst_busy", busy, 0);
        check("rst_consumed", q_consumed, 0);
        check("rst_miss", miss, 0);

        // T1: reset mid-SEND
        do_reset();
        periods[0*RW +: RW] = 32'd10;
        push(0, 8'h55);
        tick(); tick();
        enable = 1'b1;
        @(posedge clock); @(negedge clock);
        check("t1_valid_before_reset", m_valid, 1);
        #1 reset = 1'b1;
        #1;
        check("t1_m_valid", m_valid, 0);
        check("t1_m_data", m_data, 0);
        check("t1_m_source", m_source, 0);
        check("t1_busy", busy, 0);
        check("t1_consumed", q_consumed, 0);
        check("t1_miss", miss, 0);
        m_ready = 1'b1;
        #1 check("t1_no_pop_in_reset", q_consumed, 0);
        m_ready = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("t1_idle_after_release", busy, 0);
        @(posedge clock); @(negedge clock);
        check("t1_deadline_zero_miss", miss, 4'b0001);
        check("t1_regrant", m_valid, 1);
        expect_xfer(8'h55, 2'd0);
        tick();
        m_ready = 1'b1;
        wait_drain(10, "t1");

        // T2: single queue, two entries
        do_reset();
        periods[0*RW +: RW] = 32'd20;
        push(0, 8'hA5);
        push(0, 8'h3C);
        m_ready = 1'b1;
        tick(); tick();
        check("t2_no_grant_disabled", busy, 0);
        expect_xfer(8'hA5, 2'd0);
        expect_xfer(8'h3C, 2'd0);
        enable = 1'b1;
        @(posedge clock); @(negedge clock);
        check("t2_latency_valid", m_valid, 1);
        check("t2_first_data", m_data, 8'hA5);
        wait_drain(20, "t2");
        check("t2_xfer_count", hs_cyc.size(), 2);
        if (hs_cyc.size() >= 2) check("t2_service_gap", hs_cyc[1] - hs_cyc[0], 3);
        repeat (4) @(negedge clock);
        check("t2_idle_busy", busy, 0);
        check("t2_idle_valid", m_valid, 0);
        check("t2_q0_empty", q_empty[0], 1);

        // T3: EDF order with a masked queue
        do_reset();
        periods = {32'd0, 32'd25, 32'd10, 32'd40};
        tick(); tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < NQ; i++) push(i, 8'(8'h30 + i));
        expect_xfer(8'h31, 2'd1);
        expect_xfer(8'h32, 2'd2);
        expect_xfer(8'h30, 2'd0);
        m_ready = 1'b1;
        wait_drain(40, "t3");
        repeat (6) @(negedge clock);
        check("t3_masked_q3_untouched", q_empty[3], 0);
        check("t3_idle_busy", busy, 0);

        // T4: equal periods, ties and post-reload order
        do_reset();
        periods = {32'd8, 32'd8, 32'd8, 32'd8};
        push(0, 8'h40); push(0, 8'h41);
        push(1, 8'h42); push(2, 8'h43); push(3, 8'h44);
        tick(); tick();
        expect_xfer(8'h40, 2'd0);
        expect_xfer(8'h42, 2'd1);
        expect_xfer(8'h43, 2'd2);
        expect_xfer(8'h44, 2'd3);
        expect_xfer(8'h41, 2'd0);
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_drain(60, "t4");

        // T5: backpressure with enable and periods churning
        do_reset();
        periods[2*RW +: RW] = 32'd50;
        push(2, 8'h77);
        tick(); tick();
        enable = 1'b1;
        @(posedge clock); @(negedge clock);
        check("t5_valid", m_valid, 1);
        expect_xfer(8'h77, 2'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            enable = ~enable;
            periods[2*RW +: RW] = 32'(5 + k);
            periods[0*RW +: RW] = 32'(k);
            @(negedge clock);
            check($sformatf("t5_hold_valid_%0d", k), m_valid, 1);
            check($sformatf("t5_hold_data_%0d", k), m_data, 8'h77);
            check($sformatf("t5_hold_source_%0d", k), m_source, 2);
            check($sformatf("t5_hold_consumed_%0d", k), q_consumed, 0);
        end
        tick();
        enable  = 1'b0;
        m_ready = 1'b1;
        wait_drain(10, "t5");
        repeat (3) @(negedge clock);
        check("t5_idle_busy", busy, 0);

        // T6: deadline miss while another queue holds the port
        do_reset();
        periods[0*RW +: RW] = 32'd3;
        periods[1*RW +: RW] = 32'd100;
        push(1, 8'h61);
        tick(); tick();
        enable = 1'b1;
        @(posedge clock); @(negedge clock);
        check("t6_q1_granted", m_source, 1);
        #1 push(0, 8'h60);
        repeat (5) @(negedge clock);
        check("t6_miss0_set", miss[0], 1);
        check("t6_miss1_clear", miss[1], 0);
        expect_xfer(8'h61, 2'd1);
        expect_xfer(8'h60, 2'd0);
        tick();
        m_ready = 1'b1;
        wait_drain(20, "t6");
        check("t6_miss_sticky", miss, 4'b0001);

        // Table: first grant for assorted period/occupancy patterns
        for (int v = 0; v < 8; v++) begin
            do_reset();
            periods = vecs[v].p;
            for (int i = 0; i < NQ; i++)
                if (vecs[v].mask[i]) push(i, 8'(8'h10 + i));
            tick(); tick();
            enable = 1'b1;
            @(posedge clock); @(negedge clock);
            check($sformatf("vec%0d_valid", v), m_valid, vecs[v].grant);
            check($sformatf("vec%0d_busy", v), busy, vecs[v].grant);
            if (vecs[v].grant) begin
                check($sformatf("vec%0d_source", v), m_source, vecs[v].src);
                check($sformatf("vec%0d_data", v), m_data, 8'(8'h10 + vecs[v].src));
            end
        end

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
